// File: rtl/segre_pkg.sv
// Shared SEGRE types and sizes: cache line and address widths, plus the
// state and owner encodings used by the memory arbiter.
package segre_pkg;

    localparam int CACHE_LINE_SIZE_BYTES = 16;
    localparam int ADDR_SIZE             = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_ICACHE,
        OWN_DCACHE
    } arb_owner_e;

endpackage

// File: rtl/segre_mem_arbiter.sv
// Shares the single main-memory port between icache and dcache, one transaction at a time.
// Optional feature: define SEGRE_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: dcache wins ties).
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int LINE_BYTES = CACHE_LINE_SIZE_BYTES,
    parameter int ADDR_W     = ADDR_SIZE
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,

    input  logic                    ic_rd_i,
    input  logic [ADDR_W-1:0]       ic_addr_i,
    output logic                    ic_ready_o,
    output logic [LINE_BYTES*8-1:0] ic_line_o,

    input  logic                    dc_rd_i,
    input  logic                    dc_wr_i,
    input  logic [ADDR_W-1:0]       dc_addr_i,
    input  logic [LINE_BYTES*8-1:0] dc_line_i,
    output logic                    dc_ready_o,
    output logic [LINE_BYTES*8-1:0] dc_line_o,

    output logic                    mem_rd_o,
    output logic                    mem_wr_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_line_o,
    input  logic                    mem_ready_i,
    input  logic [LINE_BYTES*8-1:0] mem_line_i,

    output logic                    arb_busy_o
);

    localparam int LINE_W = LINE_BYTES * 8;

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    arb_owner_e        owner_d;
    logic              memRd_q;
    logic              memWr_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [LINE_W-1:0] memLine_q;
    logic              icReady_q;
    logic              dcReady_q;
    logic [LINE_W-1:0] icLine_q;
    logic [LINE_W-1:0] dcLine_q;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    arb_owner_e        lastGrant_q;
`endif

    logic icReq;
    logic dcReq;

    assign icReq = ic_rd_i;
    assign dcReq = dc_rd_i | dc_wr_i;

    // Grant pick; only consumed while idle, so it may look at raw requests freely.
    always_comb begin
        owner_d = OWN_NONE;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
        if (icReq && dcReq) begin
            owner_d = (lastGrant_q == OWN_ICACHE) ? OWN_DCACHE : OWN_ICACHE;
        end else if (dcReq) begin
            owner_d = OWN_DCACHE;
        end else if (icReq) begin
            owner_d = OWN_ICACHE;
        end
`else
        if (dcReq) begin
            owner_d = OWN_DCACHE;
        end else if (icReq) begin
            owner_d = OWN_ICACHE;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            memAddr_q   <= '0;
            memLine_q   <= '0;
            icReady_q   <= 1'b0;
            dcReady_q   <= 1'b0;
            icLine_q    <= '0;
            dcLine_q    <= '0;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
            lastGrant_q <= OWN_ICACHE;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    icReady_q <= 1'b0;
                    dcReady_q <= 1'b0;
                    if (owner_d == OWN_DCACHE) begin
                        owner_q   <= OWN_DCACHE;
                        memAddr_q <= dc_addr_i;
                        // A writeback beats a simultaneous read; dcache re-presents the read later.
                        memWr_q   <= dc_wr_i;
                        memRd_q   <= ~dc_wr_i;
                        memLine_q <= dc_wr_i ? dc_line_i : '0;
                        state_q   <= ARB_WAIT;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
                        lastGrant_q <= OWN_DCACHE;
`endif
                    end else if (owner_d == OWN_ICACHE) begin
                        owner_q   <= OWN_ICACHE;
                        memAddr_q <= ic_addr_i;
                        memWr_q   <= 1'b0;
                        memRd_q   <= 1'b1;
                        memLine_q <= '0;
                        state_q   <= ARB_WAIT;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
                        lastGrant_q <= OWN_ICACHE;
`endif
                    end
                end

                ARB_WAIT: begin
                    if (mem_ready_i) begin
                        memRd_q <= 1'b0;
                        memWr_q <= 1'b0;
                        if (owner_q == OWN_ICACHE) begin
                            icLine_q  <= mem_line_i;
                            icReady_q <= 1'b1;
                        end else if (owner_q == OWN_DCACHE) begin
                            if (!memWr_q) begin
                                dcLine_q <= mem_line_i;
                            end
                            dcReady_q <= 1'b1;
                        end
                        state_q <= ARB_RESP;
                    end
                end

                ARB_RESP: begin
                    icReady_q <= 1'b0;
                    dcReady_q <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= ARB_IDLE;
                end

                default: begin
                    state_q <= ARB_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign ic_ready_o = icReady_q;
    assign ic_line_o  = icLine_q;
    assign dc_ready_o = dcReady_q;
    assign dc_line_o  = dcLine_q;
    assign mem_rd_o   = memRd_q;
    assign mem_wr_o   = memWr_q;
    assign mem_addr_o = memAddr_q;
    assign mem_line_o = memLine_q;
    assign arb_busy_o = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed self-checking bench for segre_mem_arbiter; expected tie-break order
// follows the SEGRE_ARB_ROUND_ROBIN_EN build setting.
module tb_segre_mem_arbiter;
   import segre_pkg::*;

   localparam int LINE_W = CACHE_LINE_SIZE_BYTES * 8;
   localparam int ADDR_W = ADDR_SIZE;

   logic              clk_i;
   logic              rsn_i;
   logic              ic_rd_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic              ic_ready_o;
   logic [LINE_W-1:0] ic_line_o;
   logic              dc_rd_i;
   logic              dc_wr_i;
   logic [ADDR_W-1:0] dc_addr_i;
   logic [LINE_W-1:0] dc_line_i;
   logic              dc_ready_o;
   logic [LINE_W-1:0] dc_line_o;
   logic              mem_rd_o;
   logic              mem_wr_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_line_o;
   logic              mem_ready_i;
   logic [LINE_W-1:0] mem_line_i;
   logic              arb_busy_o;

   int vectorCount = 0;
   int missCount   = 0;

   logic [LINE_W-1:0] lineA5;
   logic [LINE_W-1:0] line5A;
   logic [LINE_W-1:0] lineC3;
   logic [LINE_W-1:0] line3C;
   logic [LINE_W-1:0] line96;
   logic [LINE_W-1:0] line11;
   logic [2:0]        expDcWins;
   logic              seen;

   segre_mem_arbiter dut (
      .clk_i       (clk_i),
      .rsn_i       (rsn_i),
      .ic_rd_i     (ic_rd_i),
      .ic_addr_i   (ic_addr_i),
      .ic_ready_o  (ic_ready_o),
      .ic_line_o   (ic_line_o),
      .dc_rd_i     (dc_rd_i),
      .dc_wr_i     (dc_wr_i),
      .dc_addr_i   (dc_addr_i),
      .dc_line_i   (dc_line_i),
      .dc_ready_o  (dc_ready_o),
      .dc_line_o   (dc_line_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_line_o  (mem_line_o),
      .mem_ready_i (mem_ready_i),
      .mem_line_i  (mem_line_i),
      .arb_busy_o  (arb_busy_o)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Hard stop in case something wedges the stimulus thread
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one cycle and land just after the edge, away from it
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Single comparison point: counts every vector and reports any miscompare
   task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                              input logic [LINE_W-1:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive the request side of both caches in one go
   task automatic applyStimulus(input logic icRd, input logic dcRd, input logic dcWr,
                                input logic [ADDR_W-1:0] icAddr, input logic [ADDR_W-1:0] dcAddr,
                                input logic [LINE_W-1:0] dcLine);
      ic_rd_i   = icRd;
      dc_rd_i   = dcRd;
      dc_wr_i   = dcWr;
      ic_addr_i = icAddr;
      dc_addr_i = dcAddr;
      dc_line_i = dcLine;
   endtask

   // Wait, with a cycle budget, for the arbiter to start a memory transaction
   task automatic waitForMem(output logic found);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_rd_o || mem_wr_o) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Main directed sequence
   initial begin
      lineA5 = {CACHE_LINE_SIZE_BYTES{8'hA5}};
      line5A = {CACHE_LINE_SIZE_BYTES{8'h5A}};
      lineC3 = {CACHE_LINE_SIZE_BYTES{8'hC3}};
      line3C = {CACHE_LINE_SIZE_BYTES{8'h3C}};
      line96 = {CACHE_LINE_SIZE_BYTES{8'h96}};
      line11 = {CACHE_LINE_SIZE_BYTES{8'h11}};
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
      expDcWins = 3'b101;
`else
      expDcWins = 3'b111;
`endif

      rsn_i       = 1'b0;
      mem_ready_i = 1'b0;
      mem_line_i  = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_busy",     arb_busy_o, 0);
      checkOutput("rst_mem_rd",   mem_rd_o,   0);
      checkOutput("rst_mem_wr",   mem_wr_o,   0);
      checkOutput("rst_mem_addr", mem_addr_o, 0);
      checkOutput("rst_mem_line", mem_line_o, 0);
      checkOutput("rst_ic_ready", ic_ready_o, 0);
      checkOutput("rst_dc_ready", dc_ready_o, 0);
      checkOutput("rst_ic_line",  ic_line_o,  0);
      checkOutput("rst_dc_line",  dc_line_o,  0);
      rsn_i = 1'b1;
      tick();

      $display("[TB] icache line fill");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, '0, '0);
      tick();
      checkOutput("ic_mem_rd",   mem_rd_o,   1);
      checkOutput("ic_mem_wr",   mem_wr_o,   0);
      checkOutput("ic_mem_addr", mem_addr_o, 32'h1000);
      checkOutput("ic_busy",     arb_busy_o, 1);
      tick();
      tick();
      ic_addr_i = 32'h1FC0;
      tick();
      checkOutput("wait_addr_stable", mem_addr_o, 32'h1000);
      checkOutput("wait_no_ready",    ic_ready_o, 0);
      ic_addr_i = 32'h1000;
      tick();
      mem_ready_i = 1'b1;
      mem_line_i  = lineA5;
      tick();
      mem_ready_i = 1'b0;
      mem_line_i  = '0;
      checkOutput("ic_ready_pulse", ic_ready_o, 1);
      checkOutput("ic_line",        ic_line_o,  lineA5);
      checkOutput("ic_dc_ready",    dc_ready_o, 0);
      checkOutput("ic_rd_cleared",  mem_rd_o,   0);
      ic_rd_i = 1'b0;
      tick();
      checkOutput("ic_ready_end", ic_ready_o, 0);
      checkOutput("ic_idle",      arb_busy_o, 0);
      checkOutput("ic_line_hold", ic_line_o,  lineA5);

      $display("[TB] dcache writeback with read also pending");
      applyStimulus(1'b0, 1'b1, 1'b1, '0, 32'h2040, line5A);
      tick();
      checkOutput("wb_mem_wr",   mem_wr_o,   1);
      checkOutput("wb_mem_rd",   mem_rd_o,   0);
      checkOutput("wb_mem_addr", mem_addr_o, 32'h2040);
      checkOutput("wb_mem_line", mem_line_o, line5A);
      tick();
      mem_ready_i = 1'b1;
      mem_line_i  = lineC3;
      tick();
      mem_ready_i = 1'b0;
      checkOutput("wb_dc_ready",   dc_ready_o, 1);
      checkOutput("wb_dc_line",    dc_line_o,  0);
      checkOutput("wb_ic_ready",   ic_ready_o, 0);
      checkOutput("wb_wr_cleared", mem_wr_o,   0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      checkOutput("wb_ready_end", dc_ready_o, 0);
      checkOutput("wb_idle",      arb_busy_o, 0);

      $display("[TB] stray mem_ready in idle and resp");
      mem_ready_i = 1'b1;
      mem_line_i  = line96;
      tick();
      checkOutput("stray_idle_busy", arb_busy_o, 0);
      checkOutput("stray_idle_ic",   ic_ready_o, 0);
      checkOutput("stray_idle_dc",   dc_ready_o, 0);
      checkOutput("stray_idle_line", ic_line_o,  lineA5);
      mem_ready_i = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'h2080, '0);
      tick();
      checkOutput("dcrd_mem_rd",   mem_rd_o,   1);
      checkOutput("dcrd_mem_addr", mem_addr_o, 32'h2080);
      mem_ready_i = 1'b1;
      mem_line_i  = line3C;
      tick();
      checkOutput("dcrd_ready", dc_ready_o, 1);
      checkOutput("dcrd_line",  dc_line_o,  line3C);
      mem_line_i = line96;
      dc_rd_i    = 1'b0;
      tick();
      checkOutput("stray_resp_ready", dc_ready_o, 0);
      checkOutput("stray_resp_busy",  arb_busy_o, 0);
      checkOutput("stray_resp_line",  dc_line_o,  line3C);
      mem_ready_i = 1'b0;
      tick();

      $display("[TB] async reset mid transaction");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h1100, '0, '0);
      tick();
      checkOutput("ar_pre_rd", mem_rd_o, 1);
      #2;
      rsn_i = 1'b0;
      #1;
      checkOutput("ar_busy",     arb_busy_o, 0);
      checkOutput("ar_mem_rd",   mem_rd_o,   0);
      checkOutput("ar_mem_addr", mem_addr_o, 0);
      checkOutput("ar_ic_line",  ic_line_o,  0);
      checkOutput("ar_dc_line",  dc_line_o,  0);
      tick();
      rsn_i = 1'b1;
      tick();
      checkOutput("ar_regrant_rd",   mem_rd_o,   1);
      checkOutput("ar_regrant_addr", mem_addr_o, 32'h1100);
      mem_ready_i = 1'b1;
      mem_line_i  = line11;
      tick();
      mem_ready_i = 1'b0;
      checkOutput("ar_ic_ready", ic_ready_o, 1);
      checkOutput("ar_ic_fill",  ic_line_o,  line11);
      ic_rd_i = 1'b0;
      tick();

      $display("[TB] simultaneous requests, three transactions");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000, 32'h4000, '0);
      for (int k = 0; k < 3; k++) begin
         waitForMem(seen);
         checkOutput($sformatf("tie%0d_grant", k), seen, 1);
         checkOutput($sformatf("tie%0d_addr", k), mem_addr_o,
                     expDcWins[k] ? 32'h4000 : 32'h3000);
         mem_ready_i = 1'b1;
         mem_line_i  = line96;
         tick();
         mem_ready_i = 1'b0;
         checkOutput($sformatf("tie%0d_dc_ready", k), dc_ready_o, expDcWins[k]);
         checkOutput($sformatf("tie%0d_ic_ready", k), ic_ready_o, !expDcWins[k]);
         if (k == 2) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
         end
         tick();
      end
      tick();
      checkOutput("tie_done_idle", arb_busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
